// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port.
// LSU (req1) has priority; ALU (req0) wins after MAX_WAIT losses. WB_FWD_EN adds bypass.
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0_valid,
  input  logic [ADDR_W-1:0]              req0_addr,
  input  logic [DATA_W-1:0]              req0_data,
  output logic                           req0_ready,
  input  logic                           req1_valid,
  input  logic [ADDR_W-1:0]              req1_addr,
  input  logic [DATA_W-1:0]              req1_data,
  output logic                           req1_ready,
  output logic                           rf_we,
  output logic [ADDR_W-1:0]              rf_addr,
  output logic [DATA_W-1:0]              rf_wdata,
  output logic [$clog2(MAX_WAIT+1)-1:0]  starve_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]              fwd_addr_1,
  input  logic [ADDR_W-1:0]              fwd_addr_2,
  output logic                           fwd_hit_1,
  output logic                           fwd_hit_2,
  output logic [DATA_W-1:0]              fwd_data
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_force;
  logic              w_g0;
  logic              w_g1;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_force = (r_cnt == CNT_MAX);

  // Grants are forced low during reset so no source sees a phantom accept.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!rst) begin
      if (w_force) begin
        if (req0_valid)      w_g0 = 1'b1;
        else if (req1_valid) w_g1 = 1'b1;
      end else begin
        if (req1_valid)      w_g1 = 1'b1;
        else if (req0_valid) w_g0 = 1'b1;
      end
    end
  end

  assign w_xfer = w_g0 | w_g1;
  assign w_addr = w_g1 ? req1_addr : req0_addr;
  assign w_data = w_g1 ? req1_data : req0_data;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_g0)
      w_cnt_nxt = '0;
    else if (req0_valid && w_g1 && r_cnt != CNT_MAX)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      // x0 writes are accepted but never reach the register file.
      r_we  <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign rf_we      = r_we;
  assign rf_addr    = r_addr;
  assign rf_wdata   = r_data;
  assign starve_cnt = r_cnt;

`ifdef WB_FWD_EN
  assign fwd_hit_1 = r_we && (r_addr == fwd_addr_1) && (fwd_addr_1 != '0);
  assign fwd_hit_2 = r_we && (r_addr == fwd_addr_2) && (fwd_addr_2 != '0);
  assign fwd_data  = r_data;
`endif

endmodule
